// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and helpers for the sequential binary-to-BCD
// converter (bin2bcd_seq).
//   state_e   : converter FSM states (IDLE, SHIFT, DONE)
//   DIGIT_W   : bits per packed BCD digit
//   pow10(d)  : constant function returning 10**d, used for the overflow bound
package bin2bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic longint unsigned pow10(input int unsigned d);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < d; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3: combinational double-dabble digit corrector.
//   din  [3:0] : scratch digit before the shift
//   dout [3:0] : din + 3 when din >= 5, otherwise din
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary-to-BCD converter.
// One conversion takes N shift cycles plus a DONE cycle; bcd is held between
// conversions so downstream 7-segment decoders never see partial results.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : conversion request, sampled only in IDLE
//   binary     : N-bit unsigned value, captured on the accepted start edge
//   busy       : high from the edge after acceptance through the done cycle
//   done       : one-cycle pulse when bcd is updated
//   bcd        : DIGITS packed digits, bcd[3:0] = units
//   ovf        : only when BIN2BCD_OVF_EN is defined; set on done when the
//                captured value exceeded 10**DIGITS-1 (bcd then saturates
//                to all nines). Without the macro bcd is binary mod 10**DIGITS.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned N      = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [N-1:0]                 binary,
  output logic                         busy,
  output logic                         done,
  output logic [DIGIT_W*DIGITS-1:0]    bcd
`ifdef BIN2BCD_OVF_EN
  ,
  output logic                         ovf
`endif
);

  localparam int unsigned SCR_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(N + 1);

  state_e             state_q, state_d;
  logic [N-1:0]       shift_q, shift_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [SCR_W-1:0]   scr_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SCR_W-1:0]   bcd_q, bcd_d;
`ifdef BIN2BCD_OVF_EN
  localparam longint unsigned OVF_MAX = pow10(DIGITS) - 1;
  logic               ovf_pend_q, ovf_pend_d;
  logic               ovf_q, ovf_d;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .din  (scr_q[g*DIGIT_W +: DIGIT_W]),
      .dout (scr_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    // busy/done are registered from the current state, so busy rises one
    // edge after acceptance and falls one edge after the done cycle.
    busy_d  = (state_q != IDLE);
    done_d  = (state_q == DONE);
`ifdef BIN2BCD_OVF_EN
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = binary;
          scr_d   = '0;
          cnt_d   = CNT_W'(N);
          state_d = SHIFT;
`ifdef BIN2BCD_OVF_EN
          ovf_pend_d = (64'(binary) > OVF_MAX);
`endif
        end
      end
      SHIFT: begin
        // Correct first, then shift; bits leaving the top digit are dropped.
        {scr_d, shift_d} = {scr_adj, shift_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = scr_q;
        state_d = IDLE;
`ifdef BIN2BCD_OVF_EN
        ovf_d = ovf_pend_q;
        if (ovf_pend_q) begin
          bcd_d = {DIGITS{4'h9}};
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
`ifdef BIN2BCD_OVF_EN
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
`ifdef BIN2BCD_OVF_EN
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
`ifdef BIN2BCD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: self-checking bench for bin2bcd_seq (N=10 and N=14 builds).
// Works with or without BIN2BCD_OVF_EN defined.
module tb_bin2bcd_seq;

  localparam int unsigned N   = 10;
  localparam int unsigned N14 = 14;
`ifdef BIN2BCD_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start, start14;
  logic [N-1:0]   binary;
  logic [N14-1:0] binary14;
  logic           busy, done, busy14, done14;
  logic [15:0]    bcd, bcd14;
`ifdef BIN2BCD_OVF_EN
  logic           ovf, ovf14;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.N(N), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .binary(binary),
    .busy(busy), .done(done), .bcd(bcd)
`ifdef BIN2BCD_OVF_EN
    , .ovf(ovf)
`endif
  );

  bin2bcd_seq #(.N(N14), .DIGITS(4)) dut14 (
    .clk(clk), .rst_n(rst_n), .start(start14), .binary(binary14),
    .busy(busy14), .done(done14), .bcd(bcd14)
`ifdef BIN2BCD_OVF_EN
    , .ovf(ovf14)
`endif
  );

  typedef struct {
    logic [N-1:0] bin;
    logic [15:0]  exp;
  } vec_t;

  // Reference: decimal digits by plain division, saturating when enabled.
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    if (OVF_EN && v > 9999) return 16'h9999;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v);
    return OVF_EN && (v > 9999);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done on the N=10 instance; optionally scrambles binary.
  task automatic await_done(input bit scramble, input logic [15:0] held,
                            output int lat, output int bcnt, output int hold_bad);
    lat = 0; bcnt = 0; hold_bad = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (scramble) binary = N'($urandom);
      tick();
      lat++;
      if (busy === 1'b1) bcnt++;
      if (done !== 1'b1 && bcd !== held) hold_bad++;
    end
  endtask

  task automatic convert(input logic [N-1:0] v, input logic [15:0] exp, input bit scramble);
    logic [15:0] held;
    int lat, bcnt, hb;
    held = bcd;
    binary = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_at_accept", busy, 0);
    await_done(scramble, held, lat, bcnt, hb);
    check("latency", lat, N + 1);
    check("bcd", bcd, exp);
    check("busy_cycles", bcnt, N + 1);
    check("bcd_hold", hb, 0);
`ifdef BIN2BCD_OVF_EN
    check("ovf", ovf, ref_ovf(v));
`endif
    tick();
    check("done_width", done, 0);
    check("busy_idle", busy, 0);
    check("bcd_after", bcd, exp);
  endtask

  task automatic convert14(input int unsigned v);
    int lat;
    binary14 = N14'(v);
    start14 = 1'b1;
    tick();
    start14 = 1'b0;
    lat = 0;
    while (done14 !== 1'b1 && lat < 40) begin
      binary14 = N14'($urandom);
      tick();
      lat++;
    end
    check("latency14", lat, N14 + 1);
    check("bcd14", bcd14, ref_bcd(v));
    check("busy14_on_done", busy14, 1);
`ifdef BIN2BCD_OVF_EN
    check("ovf14", ovf14, ref_ovf(v));
`endif
    tick();
    check("done14_width", done14, 0);
`ifdef BIN2BCD_OVF_EN
    check("ovf14_hold", ovf14, ref_ovf(v));
`endif
  endtask

  initial begin
    vec_t vecs[9];
    int lat, bcnt, hb, dcount;
    int unsigned rv;

    vecs[0] = '{10'd0,    16'h0000};
    vecs[1] = '{10'd1023, 16'h1023};
    vecs[2] = '{10'd999,  16'h0999};
    vecs[3] = '{10'd7,    16'h0007};
    vecs[4] = '{10'd1,    16'h0001};
    vecs[5] = '{10'd9,    16'h0009};
    vecs[6] = '{10'd10,   16'h0010};
    vecs[7] = '{10'd500,  16'h0500};
    vecs[8] = '{10'd89,   16'h0089};

    rst_n = 1'b1; start = 1'b0; start14 = 1'b0; binary = '0; binary14 = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, 16'h0000);
`ifdef BIN2BCD_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) convert(vecs[i].bin, vecs[i].exp, 1'b0);

    // start held high: second request accepted at the earliest legal edge.
    binary = 10'd999;
    start = 1'b1;
    tick();
    await_done(1'b1, bcd, lat, bcnt, hb);
    check("b2b_lat1", lat, N + 1);
    check("b2b_bcd1", bcd, 16'h0999);
    binary = 10'd7;
    tick();
    start = 1'b0;
    check("b2b_busy_gap", busy, 0);
    check("b2b_done_low", done, 0);
    await_done(1'b1, 16'h0999, lat, bcnt, hb);
    check("b2b_lat2", lat, N + 1);
    check("b2b_bcd2", bcd, 16'h0007);
    check("b2b_hold", hb, 0);
    tick();

    for (int i = 0; i < 20; i++) begin
      rv = $urandom_range(0, 1023);
      convert(N'(rv), ref_bcd(rv), 1'b1);
    end

    // Reset mid-conversion aborts it asynchronously with no done afterwards.
    binary = 10'd1023;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bcd", bcd, 16'h0000);
    tick(); tick();
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 1'b0) dcount++;
    end
    check("abort_no_done", dcount, 0);
    check("abort_bcd_held", bcd, 16'h0000);
    check("abort_idle", busy, 0);

    convert14(12000);
    convert14(9999);
    convert14(16383);
    convert14(10000);
    convert14(4321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") that turns an N-bit unsigned value into DIGITS packed BCD digits over N clock cycles. It sits directly upstream of the combinational 7-segment display decoder, which takes one BCD digit per display (units, tens, hundreds, thousands). A start/busy/done handshake lets a switch or counter front end request conversions. Results are held stable between conversions so the displays never flicker mid-conversion.

## Interface
- N, 10: width of the binary input.
- DIGITS, 4: number of BCD output digits; digit 0 is units.
- clk input 1: single clock, rising edge.
- rst_n input 1: reset, asynchronous, active-low.
- start input 1: conversion request, level-sampled in IDLE.
- binary input N: value to convert, captured on the accepted start edge.
- busy output 1: high while a conversion is in progress.
- done output 1: one-cycle pulse when bcd is updated.
- bcd output 4*DIGITS: packed digits, bcd[3:0] units, bcd[7:4] tens, and so on.
- ovf output 1: present only with BIN2BCD_OVF_EN (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start=1, capture binary into the shift register, clear the BCD scratch, load the iteration counter with N, and go to SHIFT. Otherwise stay in IDLE.
- SHIFT: every cycle, apply the add-3 correction to each scratch digit with value ≥5, then shift {scratch, shift_reg} left by 1 and decrement the counter. After the Nth shift, go to DONE.
- DONE: copy the scratch into the bcd output register, pulse done, and return to IDLE.
- start is ignored in SHIFT and DONE; there is no queuing. A changing binary input after capture has no effect.
- Scratch width is 4*DIGITS bits. Bits shifted out of the top digit are lost, so the result is binary mod 10^DIGITS.
- The iteration counter is $clog2(N+1) bits wide.
- Reset values: state=IDLE, busy=0, done=0, bcd=0, ovf=0. Internal registers are also cleared.
- Reset asserted mid-conversion aborts it immediately. The bcd output returns to 0, and no done pulse is issued for the aborted request.

## Timing
- start is sampled high in IDLE at edge k. busy=1 from edge k+1 through the cycle in which done is asserted.
- done=1 and the new bcd value appear at edge k+N+1 and last exactly one cycle. At edge k+N+2, busy=0 and the FSM is back in IDLE.
- The earliest next accepted start is at edge k+N+2, so throughput is one conversion per N+2 cycles.
- The bcd output changes only on the done cycle or on reset.

## Configuration
- BIN2BCD_OVF_EN defined:
  - Adds the ovf port.
  - On capture, compare binary against 10^DIGITS−1.
  - If the value exceeds it, on the done cycle set ovf=1 and saturate every digit of bcd to 9.
  - ovf updates only on done cycles and holds its value between conversions.
- BIN2BCD_OVF_EN undefined:
  - No ovf port and no comparator.
  - bcd carries the lower DIGITS digits (mod 10^DIGITS).

## Structure
- Package bin2bcd_pkg contains:
  - the state enum (IDLE, SHIFT, DONE);
  - the localparam DIGIT_W=4;
  - a constant function pow10(d) used for the overflow bound.
- Sub-module bcd_add3 is a combinational 4-bit digit corrector (in≥5 ? in+3 : in). It is instantiated once per digit via generate.

## Test plan
- Reset: assert rst_n=0 mid-run → busy=0, done=0, bcd=16'h0000 asynchronously. No done pulse follows.
- binary=0, start for 1 cycle → done at edge k+11, bcd=16'h0000.
- binary=1023 → bcd=16'h1023, done is exactly 1 cycle wide, busy high for 11 cycles.
- binary=999, then 7, issued back-to-back at the earliest legal edge → bcd=16'h0999, then 16'h0007. Second accepted start is at k+12.
- start held high throughout while binary changes during SHIFT → result matches the captured value. A new conversion begins only at k+N+2.
- N=14, DIGITS=4, binary=12000:
  - with BIN2BCD_OVF_EN → bcd=16'h9999, ovf=1;
  - without BIN2BCD_OVF_EN → bcd=16'h2000.
